// File: rtl/vending_machine.sv
// Coin-operated vending controller: single product priced at 15 units,
// accepts 5- and 10-unit coins, dispenses, and returns change or a refund.
// All outputs are registered; a coin sampled on edge N is reflected on
// out/change from edge N until edge N+1.
//
// state | meaning
// S0    | credit 0
// S5    | credit 5
// S10   | credit 10
// S_BAD | unused encoding, recovers to S0 with no event
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic       out,
  output logic [1:0] change
);

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_5      = 2'b01;
  localparam logic [1:0] COIN_10     = 2'b10;
  localparam logic [1:0] COIN_CANCEL = 2'b11;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  typedef enum logic [1:0] {
    S0    = 2'b00,
    S5    = 2'b01,
    S10   = 2'b10,
    S_BAD = 2'b11
  } state_t;

  state_t state;

  // Credit FSM with registered dispense/change outputs; reset wins over any coin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S0;
      out    <= 1'b0;
      change <= CHG_NONE;
    end else begin
      // Events last exactly one cycle, so default both outputs low.
      out    <= 1'b0;
      change <= CHG_NONE;
      case (state)
        S0: begin
          case (in)
            COIN_5:  state <= S5;
            COIN_10: state <= S10;
            default: state <= S0;  // no coin, or cancel with nothing to refund
          endcase
        end
        S5: begin
          case (in)
            COIN_NONE: state <= S5;
            COIN_5:    state <= S10;
            COIN_10: begin
              state <= S0;
              out   <= 1'b1;
            end
            COIN_CANCEL: begin
              state  <= S0;
              change <= CHG_5;
            end
            default: state <= S0;
          endcase
        end
        S10: begin
          case (in)
            COIN_NONE: state <= S10;
            COIN_5: begin
              state <= S0;
              out   <= 1'b1;
            end
            COIN_10: begin
              state  <= S0;
              out    <= 1'b1;
              change <= CHG_5;
            end
            COIN_CANCEL: begin
              state  <= S0;
              change <= CHG_10;
            end
            default: state <= S0;
          endcase
        end
        default: state <= S0;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed scenarios followed by
// random coins/resets, compared against a credit-arithmetic reference model.
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  int n_checks = 0;
  int n_fail   = 0;

  int         credit = 0;
  logic       exp_out;
  logic [1:0] exp_change;

  vending_machine dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .change (change)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: track credit in units, vend at 15, change = excess.
  task automatic model_step(input logic r, input logic [1:0] c);
    exp_out    = 1'b0;
    exp_change = 2'b00;
    if (!r) begin
      credit = 0;
    end else if (c == 2'b11) begin
      exp_change = 2'(credit / 5);
      credit     = 0;
    end else begin
      if (c == 2'b01) credit += 5;
      if (c == 2'b10) credit += 10;
      if (credit >= 15) begin
        exp_out    = 1'b1;
        exp_change = 2'((credit - 15) / 5);
        credit     = 0;
      end
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, check just after the rising edge.
  task automatic step(input logic r, input logic [1:0] c, input string tag);
    @(negedge clk);
    rst = r;
    in  = c;
    @(posedge clk);
    #1;
    model_step(r, c);
    n_checks++;
    assert (out === exp_out) else begin
      n_fail++;
      $error("FAIL %s out: observed %b expected %b", tag, out, exp_out);
    end
    n_checks++;
    assert (change === exp_change) else begin
      n_fail++;
      $error("FAIL %s change: observed %b expected %b", tag, change, exp_change);
    end
  endtask

  initial begin
    rst = 1'b0;
    in  = 2'b00;

    // Reset held two edges with a 10 coin present, then release idle.
    step(1'b0, 2'b10, "reset_a");
    step(1'b0, 2'b10, "reset_b");
    step(1'b1, 2'b00, "reset_release");
    step(1'b1, 2'b00, "idle_after_reset");

    // Three 5-coins vend exactly.
    step(1'b1, 2'b01, "three5_c1");
    step(1'b1, 2'b01, "three5_c2");
    step(1'b1, 2'b01, "three5_vend");
    step(1'b1, 2'b00, "three5_after");

    // 5 then 10 vends exact; 10 then 10 vends with 5 change.
    step(1'b1, 2'b01, "5_10_c1");
    step(1'b1, 2'b10, "5_10_vend");
    step(1'b1, 2'b10, "10_10_c1");
    step(1'b1, 2'b10, "10_10_vend");
    step(1'b1, 2'b00, "10_10_after");

    // Refunds from S10, S5, and S0.
    step(1'b1, 2'b10, "refund10_c1");
    step(1'b1, 2'b11, "refund10");
    step(1'b1, 2'b01, "refund5_c1");
    step(1'b1, 2'b11, "refund5");
    step(1'b1, 2'b11, "refund0");
    step(1'b1, 2'b00, "refund_after");

    // Credit held across idle cycles.
    step(1'b1, 2'b01, "hold_c1");
    for (int i = 0; i < 10; i++) step(1'b1, 2'b00, "hold_idle");
    step(1'b1, 2'b10, "hold_vend");

    // Back-to-back vends.
    step(1'b1, 2'b10, "b2b_c1");
    step(1'b1, 2'b01, "b2b_vend1");
    step(1'b1, 2'b10, "b2b_c2");
    step(1'b1, 2'b01, "b2b_vend2");

    // Reset mid-transaction discards credit; three 5-coins needed afterwards.
    step(1'b1, 2'b10, "midrst_c1");
    step(1'b0, 2'b01, "midrst_reset");
    step(1'b1, 2'b01, "midrst_c2");
    step(1'b1, 2'b01, "midrst_c3");
    step(1'b1, 2'b01, "midrst_vend");

    // Random coins with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [1:0] c;
      r = ($urandom_range(0, 19) != 0);
      c = 2'($urandom_range(0, 3));
      step(r, c, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
Name: vending_machine

Overview:
- Coin-operated vending controller for a single product priced at 15 units. Coins are 5 or 10 units.
- Accumulates credit, dispenses the product, and returns change or a refund.
- Sits between a coin-acceptor front end, which presents one coin code per clock, and the dispense/change actuators.

Parameters:
- None. Price is fixed at 15 units; the coin unit is 5.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- in  input  2  coin code sampled every clock: 00 = no coin, 01 = 5 units, 10 = 10 units, 11 = cancel/refund request
- out  output  1  dispense pulse; 1 for exactly one cycle when a product is vended
- change  output  2  change/refund code, valid in the same cycle as the event: 00 = none, 01 = 5 units, 10 = 10 units; 11 is never driven

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst low at a rising clk edge).
  - Reset forces state to S0 (credit 0), out=0, change=00.
  - Reset has priority over any coin input in the same cycle.
  - Reset mid-transaction discards the accumulated credit with no refund.
- States: S0 = credit 0, S5 = credit 5, S10 = credit 10. Encode in 2 bits; the unused encoding recovers to S0 with out=0, change=00.
- Outputs are registered, computed from the current state and in.
  - A coin sampled at edge N produces out/change visible from edge N until edge N+1, i.e. one-cycle latency.
  - In every cycle without an event, out=0 and change=00.
- Transitions (current state, in -> next state, out, change):
  - S0, 00 -> S0, 0, 00
  - S0, 01 -> S5, 0, 00
  - S0, 10 -> S10, 0, 00
  - S0, 11 -> S0, 0, 00 (nothing to refund)
  - S5, 00 -> S5, 0, 00 (credit held indefinitely, no timeout)
  - S5, 01 -> S10, 0, 00
  - S5, 10 -> S0, 1, 00 (exact 15)
  - S5, 11 -> S0, 0, 01 (refund 5)
  - S10, 00 -> S10, 0, 00
  - S10, 01 -> S0, 1, 00 (exact 15)
  - S10, 10 -> S0, 1, 01 (20 paid, 5 change)
  - S10, 11 -> S0, 0, 10 (refund 10)
- Each clock with a non-00 code counts as a new coin. A code held for multiple cycles is counted once per cycle; upstream is responsible for pulsing.
- out and change never stay asserted for more than one cycle per event.
- Back-to-back vends are supported: a vend cycle returns to S0, and the next cycle accepts a new coin.
- in is treated as synchronous to clk; there is no internal synchronizer.
- While rst is low the design ignores in.

Test Plan:
- Reset: rst=0 for 2 edges with in=10 -> state S0, out=0, change=00; release rst with in=00 -> outputs remain 0/00.
- Three 5-coins: in=01 for 3 consecutive cycles after reset -> S5, S10, then out=1, change=00 for one cycle, then back to S0 with out=0.
- 5 then 10: in=01, then 10 -> out=1, change=00 one cycle after the second coin; 10 then 10 -> out=1, change=01.
- Refund: in=10, then 11 -> out=0, change=10, state S0; in=01, then 11 -> change=01; in=11 in S0 -> change=00.
- Idle hold: in=01, then in=00 for 10 cycles, then in=10 -> credit held, vend with out=1, change=00.
- Reset mid-transaction: in=10, then rst=0 with in=01 -> S0, out=0, change=00; after release, in=01 ×3 is required to vend.
